// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: shared constants, opcodes and state encodings for the ALU-over-UART host
package alu_uart_pkg;
  localparam int N_BITS_DEF  = 8;
  localparam int N_TICKS_DEF = 16;
  localparam int LIMITE_DEF  = 163;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;
  typedef enum logic [2:0] {S_IDLE, S_SEND_A, S_SEND_B, S_SEND_OP, S_WAIT_RESP} host_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/alu_uart_host_rx.sv
// alu_uart_host_rx: oversampling 8N1 receiver on a shared baud tick, with glitch rejection
module alu_uart_host_rx
  import alu_uart_pkg::*;
#(
  parameter int N_BITS  = N_BITS_DEF,
  parameter int N_TICKS = N_TICKS_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic              i_rx,
  output logic [N_BITS-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_err,
  output logic              o_busy
);
  localparam int TW = $clog2(N_TICKS);
  localparam int NW = $clog2(N_BITS);
  rx_state_e state_q, state_d;
  logic [1:0] sync_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [N_BITS-1:0] sh_q, sh_d;
  logic valid_q, valid_d, ferr_q, ferr_d, rx, last;
  assign rx = sync_q[1];
  assign last = i_tick && cnt_q == TW'(N_TICKS - 1);
  assign o_data = sh_q;
  assign o_valid = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy = state_q == RX_START || state_q == RX_DATA || state_q == RX_STOP;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], i_rx};
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = i_tick ? cnt_q + 1'b1 : cnt_q;
    n_d     = n_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = RX_START;
      end
      // re-check just before mid start bit; a high line here was a glitch
      RX_START: if (i_tick && cnt_q == TW'(N_TICKS / 2 - 2)) begin
        cnt_d   = '0;
        n_d     = '0;
        state_d = rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (last) begin
        cnt_d = '0;
        sh_d  = {rx, sh_q[N_BITS-1:1]};
        n_d   = n_q + 1'b1;
        if (n_q == NW'(N_BITS - 1)) state_d = RX_STOP;
      end
      RX_STOP: if (last) begin
        cnt_d   = '0;
        valid_d = rx;
        ferr_d  = !rx;
        state_d = rx ? RX_IDLE : RX_WAIT_HIGH;
      end
      default: begin
        cnt_d = '0;
        if (rx) state_d = RX_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/alu_uart_host.sv
// alu_uart_host: sends A, B, opcode as 8N1 frames and collects the one-byte ALU result
module alu_uart_host
  import alu_uart_pkg::*;
#(
  parameter int N_BITS       = N_BITS_DEF,
  parameter int N_TICKS      = N_TICKS_DEF,
  parameter int LIMITE       = LIMITE_DEF,
  parameter int NB_CONTA     = 8,
  parameter int N_BITS_OP    = 6,
  parameter int GAP_BITS     = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [N_BITS-1:0]    i_data_a,
  input  logic [N_BITS-1:0]    i_data_b,
  input  logic [N_BITS_OP-1:0] i_op,
  input  logic                 i_rx,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic [N_BITS-1:0]    o_result,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic                 o_frame_err
);
  localparam int TW = $clog2(N_TICKS);
  localparam int BW = $clog2(N_BITS + GAP_BITS + 2);
  localparam int MW = $clog2(RESP_TIMEOUT + 1);
  host_state_e state_q, state_d;
  logic [NB_CONTA-1:0] baud_q, baud_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [MW-1:0] tmo_q, tmo_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d, cur, cur_sh, rx_data;
  logic tx_q, tx_d, done_q, done_d, tmo_p_q, tmo_p_d, ferr_q, ferr_d;
  logic tick, tick_adv, accept, bit_end, rx_valid, rx_ferr, rx_busy, resp_win;
  alu_uart_host_rx #(.N_BITS(N_BITS), .N_TICKS(N_TICKS)) u_rx (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(tick), .i_rx(i_rx),
    .o_data(rx_data), .o_valid(rx_valid), .o_frame_err(rx_ferr), .o_busy(rx_busy)
  );
  assign tick = baud_q == NB_CONTA'(LIMITE - 1);
  assign accept = state_q == S_IDLE && i_start;
  // the response timer freezes while a reply frame is arriving
  assign tick_adv = tick && !(state_q == S_WAIT_RESP && rx_busy);
  assign bit_end = tick_adv && tick_q == TW'(N_TICKS - 1);
  assign resp_win = state_q == S_SEND_OP || state_q == S_WAIT_RESP;
  assign cur = state_q == S_SEND_A ? a_q : state_q == S_SEND_B ? b_q : op_q;
  assign cur_sh = cur >> (bit_q - 1'b1);
  assign o_tx = tx_q;
  assign o_busy = state_q != S_IDLE;
  assign o_result = res_q;
  assign o_done = done_q;
  assign o_timeout = tmo_p_q;
  assign o_frame_err = ferr_q;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      tmo_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      tmo_p_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      tmo_q   <= tmo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      tmo_p_q <= tmo_p_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    baud_d  = accept || tick ? '0 : baud_q + 1'b1;
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    tmo_d   = tmo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    done_d  = 1'b0;
    tmo_p_d = 1'b0;
    ferr_d  = resp_win && rx_ferr;
    tx_d    = state_q == S_IDLE || state_q == S_WAIT_RESP || bit_q > BW'(N_BITS) ? 1'b1 :
              bit_q == '0 ? 1'b0 : cur_sh[0];
    if (accept) begin
      state_d = S_SEND_A;
      tick_d  = '0;
      bit_d   = '0;
      a_d     = i_data_a;
      b_d     = i_data_b;
      op_d    = N_BITS'(i_op);
    end else if (state_q != S_IDLE) begin
      if (tick_adv) tick_d = tick_q == TW'(N_TICKS - 1) ? '0 : tick_q + 1'b1;
      if (bit_end) bit_d = bit_q + 1'b1;
      if (resp_win && rx_valid) begin
        res_d   = rx_data;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (state_q == S_WAIT_RESP) begin
        if (bit_end) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == MW'(RESP_TIMEOUT - 1)) begin
            tmo_p_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end else if (bit_end && bit_q == BW'(state_q == S_SEND_OP ? N_BITS + 1 : N_BITS + 1 + GAP_BITS)) begin
        bit_d   = '0;
        tmo_d   = '0;
        state_d = state_q == S_SEND_A ? S_SEND_B : state_q == S_SEND_B ? S_SEND_OP : S_WAIT_RESP;
      end
    end
  end
endmodule
